appmult_mac7u: RTL and testbench

Pipelined multiply-accumulate stage for 7-bit unsigned operands. It instantiates the combinational `Mult_7_7` multiplier, registers each 14-bit product, and sums a burst of products into a wide accumulator. The burst result is then emitted through a valid/ready handshake. The block sits directly downstream of the multiplier. Any approximate `Mult_7_7` variant with the same port list can be dropped in unchanged, which is how retraining experiments swap multipliers.

---
 rtl/appmult_mac7u.sv | 151 +++++++++++++++
 tb/tb_appmult_mac7u.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/appmult_mac7u.sv
// Pipelined 7x7 unsigned multiply-accumulate with a burst result handshake.
// Optional accumulator clamping is enabled by defining APPMULT_MAC_SAT_EN.

module Mult_7_7 (
  input  logic [6:0]  IN1,
  input  logic [6:0]  IN2,
  output logic [13:0] Out
);
  assign Out = {7'b0, IN1} * {7'b0, IN2};
endmodule

module appmult_mac7u #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_a,
  input  logic [6:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and once raised it holds its data
  // until the transfer completes.

  typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_p_valid;
  logic [13:0]      r_p_prod;
  logic             r_p_last;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [13:0]      w_prod;
  logic             w_accept;
  logic             w_p_fire;
  logic             w_out_fire;
  logic [ACC_W:0]   w_sum;

  Mult_7_7 u_mult (
    .IN1 (in_a),
    .IN2 (in_b),
    .Out (w_prod)
  );

  assign w_p_fire   = r_p_valid && (r_state == ST_ACCUM);
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(r_p_prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_p_fire && r_p_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)            w_state_nxt = ST_ACCUM;
      default:                            w_state_nxt = ST_ACCUM;
    endcase
  end

  // Output logic; in_ready depends only on registers, so P freezes in DONE
  always_comb begin
    out_valid   = (r_state == ST_DONE);
    in_ready    = !r_p_valid || w_p_fire;
    o_dbg_state = r_state;
  end

  // Product stage P
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_prod  <= '0;
      r_p_last  <= 1'b0;
    end else if (w_accept) begin
      r_p_valid <= 1'b1;
      r_p_prod  <= w_prod;
      r_p_last  <= in_last;
    end else if (w_p_fire) begin
      r_p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= '0;
    end else if (w_p_fire && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef APPMULT_MAC_SAT_EN
  logic r_sat;

  // Carry out of the widened sum means the true total no longer fits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_out_fire) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_p_fire) begin
      if (w_sum[ACC_W]) begin
        r_acc <= {ACC_W{1'b1}};
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign out_sat = r_sat;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_out_fire) begin
      r_acc <= '0;
    end else if (w_p_fire) begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

  assign out_sat = 1'b0 & w_unused_carry;
`endif

  assign out_acc   = r_acc;
  assign out_count = r_count;

endmodule

// File: tb/tb_appmult_mac7u.sv
// Directed and table-driven bench for appmult_mac7u, with a narrow second
// instance for the accumulator-clamp and term-count saturation cases.

module tb_appmult_mac7u;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (ACC_W=20, CNT_W=8)
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [6:0]  in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1, out_sat, dbg_state;
  logic [19:0] out_acc;
  logic [7:0]  out_count;

  // narrow instance (ACC_W=14, CNT_W=2)
  logic        s_in_valid = 1'b0, s_in_ready, s_in_last = 1'b0;
  logic [6:0]  s_in_a = '0, s_in_b = '0;
  logic        s_out_valid, s_out_ready = 1'b1, s_out_sat, s_dbg_state;
  logic [13:0] s_out_acc;
  logic [1:0]  s_out_count;

  appmult_mac7u #(.ACC_W(20), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
    .out_sat(out_sat), .o_dbg_state(dbg_state)
  );

  appmult_mac7u #(.ACC_W(14), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_acc(s_out_acc), .out_count(s_out_count),
    .out_sat(s_out_sat), .o_dbg_state(s_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- scoreboard ----------------
  // entry = {acc[19:0], count[7:0], sat}
  logic [28:0] exp_q[$];
  logic        held = 1'b0;
  logic [28:0] held_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_acc, out_count, out_sat}, held_v);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got acc %0d count %0d expected none", out_acc, out_count);
        end else begin
          logic [28:0] e;
          e = exp_q.pop_front();
          check("out_acc", out_acc, e[28:9]);
          check("out_count", out_count, e[8:1]);
          check("out_sat", out_sat, e[0]);
        end
      end
      held   = out_valid && !out_ready;
      held_v = {out_acc, out_count, out_sat};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [6:0] a, input logic [6:0] b, input logic last);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_beat: in_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: pending results got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic s_send(input logic [6:0] a, input logic [6:0] b, input logic last);
    int n;
    s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_last = last;
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_in_ready) begin
      n_checks++;
      $display("FAIL s_send: in_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic s_expect(input string name, input logic [13:0] acc, input logic [1:0] cnt, input logic sat);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 50) begin @(negedge clk); n++; end
    if (!s_out_valid) begin
      n_checks++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
    end else begin
      check({name, "_acc"}, s_out_acc, acc);
      check({name, "_count"}, s_out_count, cnt);
      check({name, "_sat"}, s_out_sat, sat);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]  a;
    logic [6:0]  b;
    logic        last;
    logic [19:0] exp_acc;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[15];
  logic rand_done = 1'b0;

  initial begin
    int accepted;
    tbl[0]  = '{7'd1,   7'd1,   1'b1, 20'd1,     8'd1};
    tbl[1]  = '{7'd0,   7'd0,   1'b0, 20'd0,     8'd0};
    tbl[2]  = '{7'd0,   7'd127, 1'b0, 20'd0,     8'd0};
    tbl[3]  = '{7'd127, 7'd0,   1'b1, 20'd0,     8'd3};
    tbl[4]  = '{7'd127, 7'd127, 1'b0, 20'd0,     8'd0};
    tbl[5]  = '{7'd127, 7'd127, 1'b0, 20'd0,     8'd0};
    tbl[6]  = '{7'd127, 7'd127, 1'b0, 20'd0,     8'd0};
    tbl[7]  = '{7'd127, 7'd127, 1'b1, 20'd64516, 8'd4};
    tbl[8]  = '{7'd2,   7'd3,   1'b1, 20'd6,     8'd1};
    tbl[9]  = '{7'd12,  7'd11,  1'b0, 20'd0,     8'd0};
    tbl[10] = '{7'd7,   7'd9,   1'b1, 20'd195,   8'd2};
    tbl[11] = '{7'd64,  7'd64,  1'b0, 20'd0,     8'd0};
    tbl[12] = '{7'd100, 7'd50,  1'b1, 20'd9096,  8'd2};
    tbl[13] = '{7'd1,   7'd127, 1'b0, 20'd0,     8'd0};
    tbl[14] = '{7'd127, 7'd1,   1'b1, 20'd254,   8'd2};

    // reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_sat", out_sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic burst with latency profile
    send_beat(7'd3, 7'd5, 1'b0);
    send_beat(7'd10, 7'd10, 1'b0);
    exp_q.push_back({20'd16244, 8'd3, 1'b0});
    send_beat(7'd127, 7'd127, 1'b1);
    @(negedge clk); check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk); check("lat_cycle2_valid", out_valid, 1);
    @(negedge clk); check("lat_cycle3_valid", out_valid, 0);
    @(posedge clk); #1;
    drain();

    // table-driven bursts, back to back
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].last) exp_q.push_back({tbl[i].exp_acc, tbl[i].exp_cnt, 1'b0});
      send_beat(tbl[i].a, tbl[i].b, tbl[i].last);
    end
    drain();

    // back-pressure: one beat buffered, then stall
    out_ready = 1'b0;
    send_beat(7'd5, 7'd5, 1'b0);
    exp_q.push_back({20'd61, 8'd2, 1'b0});
    send_beat(7'd6, 7'd6, 1'b1);
    in_valid = 1'b1; in_a = 7'd9; in_b = 7'd9; in_last = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", accepted, 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_acc", out_acc, 61);
    exp_q.push_back({20'd97, 8'd2, 1'b0});
    out_ready = 1'b1;
    send_beat(7'd4, 7'd4, 1'b1);
    drain();

    // asynchronous reset mid-burst
    send_beat(7'd10, 7'd10, 1'b0);
    send_beat(7'd20, 7'd20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_acc", out_acc, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({20'd6, 8'd1, 1'b0});
    send_beat(7'd2, 7'd3, 1'b1);
    drain();

    // narrow instance: accumulator wrap or clamp, then term-count saturation
    s_send(7'd127, 7'd127, 1'b0);
    s_send(7'd127, 7'd127, 1'b1);
`ifdef APPMULT_MAC_SAT_EN
    s_expect("sat", 14'd16383, 2'd2, 1'b1);
`else
    s_expect("sat", 14'd15874, 2'd2, 1'b0);
`endif
    for (int i = 0; i < 6; i++) s_send(7'd1, 7'd1, i == 5);
    s_expect("cnt_sat", 14'd6, 2'd3, 1'b0);

    // random stress with random out_ready
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          int nb;
          logic [19:0] sum;
          logic [6:0] a, b;
          nb  = $urandom_range(1, 40);
          sum = '0;
          for (int i = 0; i < nb; i++) begin
            a = 7'($urandom_range(0, 127));
            b = 7'($urandom_range(0, 127));
            sum = sum + ({13'b0, a} * {13'b0, b});
            if (i == nb - 1) exp_q.push_back({sum, 8'(nb), 1'b0});
            send_beat(a, b, i == nb - 1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time got 500000 expected less");
    $fatal(1, "watchdog");
  end

endmodule
